// File: rtl/retire_stage_if.sv
// rtl/retire_stage_if.sv - ROB-to-retire handshake bundle and retire-side outputs
interface retire_stage_if #(
    parameter int N             = 2,
    parameter int ROB_SZ_BITS   = 5,
    parameter int ARCH_REG_BITS = 5,
    parameter int PHYS_REG_BITS = 6,
    parameter int NSB           = $clog2(N + 1)
);
    logic [NSB-1:0]             rob_outputs_valid;
    logic [ROB_SZ_BITS-1:0]     rob_head;
    logic [N-1:0]               out_complete;
    logic [N-1:0]               out_mispredict;
    logic [N-1:0]               out_halt;
    logic [N-1:0]               out_has_dest;
    logic [N*ARCH_REG_BITS-1:0] out_dest_arch;
    logic [N*PHYS_REG_BITS-1:0] out_dest_phys;
    logic [N*32-1:0]            out_target_pc;

    logic [NSB-1:0]             num_retiring;
    logic                       tail_restore_valid;
    logic [ROB_SZ_BITS-1:0]     tail_restore;
    logic                       redirect_valid;
    logic [31:0]                redirect_pc;
    logic [N-1:0]               amt_we;
    logic [N*ARCH_REG_BITS-1:0] amt_arch;
    logic [N*PHYS_REG_BITS-1:0] amt_phys;
    logic [31:0]                retired_count;
    logic                       halted;

    modport master (
        output rob_outputs_valid, rob_head, out_complete, out_mispredict, out_halt,
               out_has_dest, out_dest_arch, out_dest_phys, out_target_pc,
        input  num_retiring, tail_restore_valid, tail_restore, redirect_valid,
               redirect_pc, amt_we, amt_arch, amt_phys, retired_count, halted
    );

    modport slave (
        input  rob_outputs_valid, rob_head, out_complete, out_mispredict, out_halt,
               out_has_dest, out_dest_arch, out_dest_phys, out_target_pc,
        output num_retiring, tail_restore_valid, tail_restore, redirect_valid,
               redirect_pc, amt_we, amt_arch, amt_phys, retired_count, halted
    );
endinterface

// File: rtl/retire_stage.sv
// rtl/retire_stage.sv - in-order superscalar retire with mispredict recovery and halt
module retire_stage #(
    parameter int N             = 2,
    parameter int ROB_SZ_BITS   = 5,
    parameter int ARCH_REG_BITS = 5,
    parameter int PHYS_REG_BITS = 6,
    parameter int NSB           = $clog2(N + 1)
) (
    input logic           clock,
    input logic           reset,
    retire_stage_if.slave bus
);
    typedef enum logic [1:0] {RUN, RECOVER, HALTED} state_t;

    state_t                     r_state;
    logic                       r_redirect_valid;
    logic [31:0]                r_redirect_pc;
    logic [N-1:0]               r_amt_we;
    logic [N*ARCH_REG_BITS-1:0] r_amt_arch;
    logic [N*PHYS_REG_BITS-1:0] r_amt_phys;
    logic [31:0]                r_retired_count;
    logic                       r_halted;

    logic [NSB-1:0]             w_cnt;
    logic                       w_stop;
    logic                       w_last_mis;
    logic                       w_last_halt;
    logic [ROB_SZ_BITS-1:0]     w_tail;
    logic [31:0]                w_target;
    logic                       w_active;
    logic [NSB-1:0]             w_num;

    // Walk lanes oldest-first; each retiring lane overwrites the "last lane" fields,
    // and the walk stops at the first incomplete, invalid, or control-flow lane.
    always_comb begin
        w_cnt       = '0;
        w_stop      = 1'b0;
        w_last_mis  = 1'b0;
        w_last_halt = 1'b0;
        w_tail      = bus.rob_head;
        w_target    = '0;
        for (int i = 0; i < N; i++) begin
            if (!w_stop) begin
                if (i < int'(bus.rob_outputs_valid) && bus.out_complete[i]) begin
                    w_cnt       = NSB'(i + 1);
                    w_tail      = bus.rob_head + ROB_SZ_BITS'(i + 1);
                    w_target    = bus.out_target_pc[i*32 +: 32];
                    w_last_halt = bus.out_halt[i];
                    w_last_mis  = bus.out_mispredict[i] && !bus.out_halt[i];
                    w_stop      = bus.out_halt[i] || bus.out_mispredict[i];
                end else begin
                    w_stop = 1'b1;
                end
            end
        end
    end

    assign w_active = reset && (r_state == RUN);
    assign w_num    = w_active ? w_cnt : '0;

    assign bus.num_retiring       = w_num;
    assign bus.tail_restore_valid = w_active && w_last_mis;
    assign bus.tail_restore       = w_tail;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state          <= RUN;
            r_redirect_valid <= 1'b0;
            r_redirect_pc    <= '0;
            r_amt_we         <= '0;
            r_amt_arch       <= '0;
            r_amt_phys       <= '0;
            r_retired_count  <= '0;
            r_halted         <= 1'b0;
        end else begin
            r_redirect_valid <= 1'b0;
            case (r_state)
                RUN: begin
                    // Halt outranks mispredict: the flag pair on one lane never redirects.
                    if (w_last_halt) begin
                        r_state  <= HALTED;
                        r_halted <= 1'b1;
                    end else if (w_last_mis) begin
                        r_state          <= RECOVER;
                        r_redirect_valid <= 1'b1;
                        r_redirect_pc    <= w_target;
                    end
                end
                RECOVER: r_state <= RUN;
                HALTED:  r_state <= HALTED;
                default: r_state <= RUN;
            endcase
            r_retired_count <= r_retired_count + 32'(w_num);
            for (int i = 0; i < N; i++) begin
                r_amt_we[i] <= (i < int'(w_num)) && bus.out_has_dest[i];
            end
            r_amt_arch <= bus.out_dest_arch;
            r_amt_phys <= bus.out_dest_phys;
        end
    end

    assign bus.redirect_valid = r_redirect_valid;
    assign bus.redirect_pc    = r_redirect_pc;
    assign bus.amt_we         = r_amt_we;
    assign bus.amt_arch       = r_amt_arch;
    assign bus.amt_phys       = r_amt_phys;
    assign bus.retired_count  = r_retired_count;
    assign bus.halted         = r_halted;
endmodule

// File: tb/tb_retire_stage.sv
// tb/tb_retire_stage.sv - vector table, corner sequences and random run against a lane model
module tb_retire_stage;
    localparam int N   = 2;
    localparam int RB  = 5;
    localparam int AB  = 5;
    localparam int PB  = 6;
    localparam int NSB = $clog2(N + 1);

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    retire_stage_if #(.N(N), .ROB_SZ_BITS(RB), .ARCH_REG_BITS(AB), .PHYS_REG_BITS(PB)) bus();

    retire_stage #(.N(N), .ROB_SZ_BITS(RB), .ARCH_REG_BITS(AB), .PHYS_REG_BITS(PB), .NSB(NSB))
        dut (.clock(clk), .reset(rst_n), .bus(bus));

    int checks = 0;
    int failures = 0;

    int             m_state;   // 0 run, 1 recover, 2 halted
    logic [31:0]    m_count;
    logic           m_rv;
    logic [31:0]    m_rpc;
    logic [N-1:0]   m_we;
    logic [N*AB-1:0] m_arch;
    logic [N*PB-1:0] m_phys;

    typedef struct {
        int          valid;
        int          head;
        logic [N-1:0] cp;
        logic [N-1:0] mp;
        logic [N-1:0] hl;
        logic [N-1:0] hd;
        logic [31:0] t0;
        logic [31:0] t1;
        int          exp_nr;
        logic        exp_tv;
        int          exp_tail;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h @%0t", name, act, exp, $time);
        end
    endtask

    // Retire count = valid lanes, capped at the first incomplete lane,
    // then capped again just after the first flagged lane.
    function automatic void model_lanes(input int valid, input logic [N-1:0] cp,
                                        input logic [N-1:0] mp, input logic [N-1:0] hl,
                                        output int cnt, output int k);
        int lim;
        lim = (valid > N) ? N : valid;
        for (int i = 0; i < lim; i++) if (!cp[i]) begin lim = i; break; end
        cnt = lim;
        for (int i = 0; i < lim; i++) if (mp[i] || hl[i]) begin cnt = i + 1; break; end
        k = cnt - 1;
    endfunction

    task automatic cycle(input int valid, input int head, input logic [N-1:0] cp,
                         input logic [N-1:0] mp, input logic [N-1:0] hl, input logic [N-1:0] hd,
                         input logic [N*32-1:0] tgt,
                         output int a_nr, output logic a_tv, output int a_tail);
        logic [N*AB-1:0] arch;
        logic [N*PB-1:0] phys;
        int cnt, k, nr;
        logic tv, hv;
        arch = (N*AB)'($urandom);
        phys = (N*PB)'($urandom);
        bus.rob_outputs_valid = NSB'(valid);
        bus.rob_head          = RB'(head);
        bus.out_complete      = cp;
        bus.out_mispredict    = mp;
        bus.out_halt          = hl;
        bus.out_has_dest      = hd;
        bus.out_dest_arch     = arch;
        bus.out_dest_phys     = phys;
        bus.out_target_pc     = tgt;
        #4;
        a_nr   = int'(bus.num_retiring);
        a_tv   = bus.tail_restore_valid;
        a_tail = int'(bus.tail_restore);
        model_lanes(valid, cp, mp, hl, cnt, k);
        nr = 0; tv = 1'b0; hv = 1'b0;
        if (m_state == 0) begin
            nr = cnt;
            hv = (cnt > 0) && hl[k];
            tv = (cnt > 0) && mp[k] && !hv;
        end
        chk("num_retiring", 64'(a_nr), 64'(nr));
        chk("tail_restore_valid", 64'(a_tv), 64'(tv));
        if (tv) chk("tail_restore", 64'(a_tail), 64'((head + k + 1) % 32));
        m_count = m_count + 32'(nr);
        m_rv = tv;
        if (tv) m_rpc = tgt[k*32 +: 32];
        for (int i = 0; i < N; i++) m_we[i] = (i < nr) && hd[i];
        m_arch = arch;
        m_phys = phys;
        if (hv) m_state = 2;
        else if (tv) m_state = 1;
        else if (m_state == 1) m_state = 0;
        @(posedge clk);
        #1;
        chk("redirect_valid", 64'(bus.redirect_valid), 64'(m_rv));
        chk("redirect_pc", 64'(bus.redirect_pc), 64'(m_rpc));
        chk("retired_count", 64'(bus.retired_count), 64'(m_count));
        chk("halted", 64'(bus.halted), 64'(m_state == 2));
        for (int i = 0; i < N; i++) begin
            chk("amt_we", 64'(bus.amt_we[i]), 64'(m_we[i]));
            if (m_we[i]) begin
                chk("amt_arch", 64'(bus.amt_arch[i*AB +: AB]), 64'(m_arch[i*AB +: AB]));
                chk("amt_phys", 64'(bus.amt_phys[i*PB +: PB]), 64'(m_phys[i*PB +: PB]));
            end
        end
    endtask

    task automatic do_reset();
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_redirect_valid", 64'(bus.redirect_valid), 64'd0);
        chk("rst_redirect_pc", 64'(bus.redirect_pc), 64'd0);
        chk("rst_retired_count", 64'(bus.retired_count), 64'd0);
        chk("rst_halted", 64'(bus.halted), 64'd0);
        chk("rst_amt_we", 64'(bus.amt_we), 64'd0);
        chk("rst_num_retiring", 64'(bus.num_retiring), 64'd0);
        chk("rst_tail_restore_valid", 64'(bus.tail_restore_valid), 64'd0);
        m_state = 0; m_count = '0; m_rv = 1'b0; m_rpc = '0; m_we = '0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    vec_t vecs[13];

    initial begin
        int nr;
        logic tv;
        int tail;
        vec_t v;
        logic [N-1:0] cp, mp, hl;

        vecs[0]  = '{2,  3, 2'b11, 2'b00, 2'b00, 2'b01, 32'h0,    32'h0,    2, 1'b0, 0};
        vecs[1]  = '{2,  3, 2'b10, 2'b00, 2'b00, 2'b11, 32'h0,    32'h0,    0, 1'b0, 0};
        vecs[2]  = '{1,  4, 2'b11, 2'b00, 2'b00, 2'b11, 32'h0,    32'h0,    1, 1'b0, 0};
        vecs[3]  = '{0,  4, 2'b11, 2'b00, 2'b00, 2'b11, 32'h0,    32'h0,    0, 1'b0, 0};
        vecs[4]  = '{2,  5, 2'b01, 2'b00, 2'b00, 2'b11, 32'h0,    32'h0,    1, 1'b0, 0};
        vecs[5]  = '{2,  5, 2'b11, 2'b10, 2'b00, 2'b10, 32'h44,   32'h2340, 2, 1'b1, 7};
        vecs[6]  = '{2,  7, 2'b11, 2'b00, 2'b00, 2'b11, 32'h0,    32'h0,    0, 1'b0, 0};
        vecs[7]  = '{2, 31, 2'b11, 2'b01, 2'b00, 2'b11, 32'h1000, 32'h8888, 1, 1'b1, 0};
        vecs[8]  = '{2,  0, 2'b11, 2'b00, 2'b00, 2'b11, 32'h0,    32'h0,    0, 1'b0, 0};
        vecs[9]  = '{2,  0, 2'b01, 2'b10, 2'b00, 2'b11, 32'h0,    32'h0,    1, 1'b0, 0};
        vecs[10] = '{1,  1, 2'b11, 2'b10, 2'b00, 2'b11, 32'h0,    32'h77,   1, 1'b0, 0};
        vecs[11] = '{2,  2, 2'b11, 2'b01, 2'b01, 2'b11, 32'h500,  32'h0,    1, 1'b0, 0};
        vecs[12] = '{2,  3, 2'b11, 2'b00, 2'b00, 2'b11, 32'h0,    32'h0,    0, 1'b0, 0};

        m_state = 0; m_count = '0; m_rv = 1'b0; m_rpc = '0; m_we = '0; m_arch = '0; m_phys = '0;
        bus.rob_outputs_valid = NSB'(2);
        bus.rob_head = '0;
        bus.out_complete = 2'b11;
        bus.out_mispredict = '0;
        bus.out_halt = '0;
        bus.out_has_dest = 2'b11;
        bus.out_dest_arch = '0;
        bus.out_dest_phys = '0;
        bus.out_target_pc = '0;
        #1 rst_n = 1'b0;
        #2;
        chk("init_num_retiring", 64'(bus.num_retiring), 64'd0);
        chk("init_tail_restore_valid", 64'(bus.tail_restore_valid), 64'd0);
        chk("init_redirect_valid", 64'(bus.redirect_valid), 64'd0);
        chk("init_retired_count", 64'(bus.retired_count), 64'd0);
        chk("init_halted", 64'(bus.halted), 64'd0);
        chk("init_amt_we", 64'(bus.amt_we), 64'd0);
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;

        for (int i = 0; i < 13; i++) begin
            v = vecs[i];
            cycle(v.valid, v.head, v.cp, v.mp, v.hl, v.hd, {v.t1, v.t0}, nr, tv, tail);
            chk($sformatf("vec%0d_nr", i), 64'(nr), 64'(v.exp_nr));
            chk($sformatf("vec%0d_tv", i), 64'(tv), 64'(v.exp_tv));
            if (v.exp_tv) chk($sformatf("vec%0d_tail", i), 64'(tail), 64'(v.exp_tail));
        end
        do_reset();

        // Halt on lane 1 retires both lanes, then nothing retires until reset.
        cycle(2, 9, 2'b11, 2'b00, 2'b10, 2'b11, '0, nr, tv, tail);
        chk("v4_nr", 64'(nr), 64'd2);
        chk("v4_halted", 64'(bus.halted), 64'd1);
        for (int i = 0; i < 3; i++) begin
            cycle(2, i, 2'b11, 2'($urandom), 2'b00, 2'b11, {32'h10, 32'h20}, nr, tv, tail);
            chk("v4_frozen_nr", 64'(nr), 64'd0);
        end
        do_reset();

        // Reset landing inside the recovery cycle clears the pending redirect at once.
        cycle(2, 31, 2'b11, 2'b01, 2'b00, 2'b11, {32'h0, 32'h1000}, nr, tv, tail);
        chk("v6_redirect_before", 64'(bus.redirect_valid), 64'd1);
        do_reset();
        cycle(2, 0, 2'b11, 2'b00, 2'b00, 2'b11, '0, nr, tv, tail);
        chk("v6_run_after_reset", 64'(nr), 64'd2);

        for (int n = 0; n < 300; n++) begin
            cp = 2'($urandom);
            mp = {($urandom_range(0, 5) == 0), ($urandom_range(0, 5) == 0)};
            hl = {($urandom_range(0, 40) == 0), ($urandom_range(0, 40) == 0)};
            cycle($urandom_range(0, 2), $urandom_range(0, 31), cp, mp, hl, 2'($urandom),
                  {$urandom, $urandom}, nr, tv, tail);
            if (m_state == 2 && $urandom_range(0, 3) == 0) do_reset();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
